// File: rtl/cordic_pkg.sv
// cordic_pkg: shared definitions for the CORDIC angle front/back adapter.
//   W        : data width of the Q6.10 two's complement format
//   M, N     : integer / fractional bit split of that format
//   PI       : pi in Q6.10
//   HALF_PI  : pi/2 in Q6.10
//   K        : CORDIC gain compensation (0.60725 * 1024) used as x0
//   cordic_res_t : one {cos, sin} result as held in the result FIFO
package cordic_pkg;

    localparam int W = 16;
    localparam int M = 6;
    localparam int N = 10;

    localparam logic signed [W-1:0] PI      = 16'sd3217;
    localparam logic signed [W-1:0] HALF_PI = 16'sd1608;
    localparam logic signed [W-1:0] K       = 16'sd622;

    typedef struct packed {
        logic signed [W-1:0] cos;
        logic signed [W-1:0] sin;
    } cordic_res_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo: first-word fall-through FIFO for CORDIC results.
// The head entry is presented on pop_data whenever empty = 0, and reads as
// zero while the FIFO is empty. Overflow is prevented by the caller.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags
module cordic_result_fifo
    import cordic_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/cordic_angle_front.sv
// cordic_angle_front: front/back adapter around an 11-stage Q6.10 CORDIC
// rotation pipeline. Accepted angles are range-reduced to [-pi/2, pi/2] and
// launched as (x0, y0, z0) = (K, 0, z). A tag line follows each sample through
// the pipeline; on exit the pipeline x/y are sign-corrected into cos/sin and
// buffered in a FWFT FIFO. A credit counter throttles acceptance so the
// FIFO, which cannot backpressure the pipeline, never overflows.
//   in_valid/in_ready/in_angle : angle input handshake (Q6.10 radians)
//   x0, y0, z0                 : launch values to the pipeline
//   pipe_x, pipe_y             : pipeline out_x / out_y
//   out_valid/out_ready        : result handshake, pop on valid & ready
//   out_cos, out_sin           : FIFO head, Q6.10
//   err                        : sticky out-of-range flag
// Build option: define CORDIC_RANGE_CHECK_EN to clamp accepted angles to
// [-PI, PI] and expose the err port.
module cordic_angle_front #(
    parameter int W          = 16,
    parameter int PIPE_LAT   = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_angle,
    output logic [W-1:0] x0,
    output logic [W-1:0] y0,
    output logic [W-1:0] z0,
    input  logic [W-1:0] pipe_x,
    input  logic [W-1:0] pipe_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_sin
`ifdef CORDIC_RANGE_CHECK_EN
    ,
    output logic         err
`endif
);

    import cordic_pkg::*;

    localparam logic signed [W-1:0] PI_W           = PI;
    localparam logic signed [W-1:0] NEG_PI_W       = -PI;
    localparam logic signed [W-1:0] HALF_PI_W      = HALF_PI;
    localparam logic signed [W-1:0] NEG_HALF_PI_W  = -HALF_PI;
    localparam logic [W-1:0]        K_W            = K;
    localparam int                  CW             = $clog2(FIFO_DEPTH + 1);

    logic                accept;
    logic                pop;
    logic signed [W-1:0] ang_c;
    logic signed [W:0]   z_wide;
    logic                flip;

    logic [W-1:0]        x0_q, x0_d;
    logic [W-1:0]        y0_q, y0_d;
    logic [W-1:0]        z0_q, z0_d;
    logic [PIPE_LAT:0]   tag_v_q, tag_v_d;
    logic [PIPE_LAT:0]   tag_f_q, tag_f_d;
    logic                res_vld_q, res_vld_d;
    cordic_res_t         res_q, res_d;
    logic [CW-1:0]       credits_q, credits_d;

    logic                fifo_full;
    logic                fifo_empty;
    cordic_res_t         fifo_head;

`ifdef CORDIC_RANGE_CHECK_EN
    logic                err_q, err_d;
    assign err = err_q;
`endif

    assign in_ready = (credits_q != '0);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // ---- input: range reduction into the CORDIC convergence range ----
    always_comb begin
        ang_c = $signed(in_angle);
`ifdef CORDIC_RANGE_CHECK_EN
        err_d = err_q;
        if (ang_c > PI_W) begin
            ang_c = PI_W;
            err_d = err_q | accept;
        end else if (ang_c < NEG_PI_W) begin
            ang_c = NEG_PI_W;
            err_d = err_q | accept;
        end
`endif
        // One extra bit so +/-PI shifts cannot overflow before truncation.
        z_wide = (W+1)'(ang_c);
        flip   = 1'b0;
        if (ang_c > HALF_PI_W) begin
            z_wide = (W+1)'(ang_c) - (W+1)'(PI_W);
            flip   = 1'b1;
        end else if (ang_c < NEG_HALF_PI_W) begin
            z_wide = (W+1)'(ang_c) + (W+1)'(PI_W);
            flip   = 1'b1;
        end
    end

    // ---- front register and tag line ----
    always_comb begin
        x0_d    = accept ? K_W : x0_q;
        y0_d    = accept ? '0 : y0_q;
        z0_d    = accept ? z_wide[W-1:0] : z0_q;
        tag_v_d = {tag_v_q[PIPE_LAT-1:0], accept};
        tag_f_d = {tag_f_q[PIPE_LAT-1:0], flip};
    end

    // ---- result stage: undo the pi shift by negating both components ----
    always_comb begin
        res_vld_d   = tag_v_q[PIPE_LAT];
        res_d.cos   = tag_f_q[PIPE_LAT] ? -$signed(pipe_x) : $signed(pipe_x);
        res_d.sin   = tag_f_q[PIPE_LAT] ? -$signed(pipe_y) : $signed(pipe_y);
    end

    // Credits count free FIFO slots minus samples already in flight.
    always_comb begin
        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !accept) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q      <= '0;
            y0_q      <= '0;
            z0_q      <= '0;
            tag_v_q   <= '0;
            tag_f_q   <= '0;
            res_vld_q <= 1'b0;
            credits_q <= CW'(FIFO_DEPTH);
`ifdef CORDIC_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            z0_q      <= z0_d;
            tag_v_q   <= tag_v_d;
            tag_f_q   <= tag_f_d;
            res_vld_q <= res_vld_d;
            credits_q <= credits_d;
`ifdef CORDIC_RANGE_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign x0 = x0_q;
    assign y0 = y0_q;
    assign z0 = z0_q;

    // ---- output: FWFT result buffer ----
    cordic_result_fifo #(
        .DW    ($bits(cordic_res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_vld_q & ~fifo_full),
        .push_data (res_q),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_cos   = fifo_head.cos;
    assign out_sin   = fifo_head.sin;

endmodule

// File: tb/tb_cordic_angle_front.sv
// Bench for cordic_angle_front. The CORDIC pipeline is stood in for by an
// ideal 11-cycle rotation model (gain included); expected results come from
// cos/sin of the original angle, scaled to Q6.10.
`timescale 1ns/1ps
module tb_cordic_angle_front;

    localparam int  W          = 16;
    localparam int  PIPE_LAT   = 11;
    localparam int  FIFO_DEPTH = 4;
    localparam real GAIN       = 1.6467602581;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_angle;
    logic [W-1:0] x0, y0, z0;
    logic [W-1:0] pipe_x, pipe_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_cos, out_sin;
`ifdef CORDIC_RANGE_CHECK_EN
    logic         err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int pops    = 0;

    always #5 clk = ~clk;

    cordic_angle_front #(
        .W          (W),
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .pipe_x    (pipe_x),
        .pipe_y    (pipe_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin)
`ifdef CORDIC_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    function automatic int q10(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    // Ideal rotation of (x, y) by z, with the CORDIC gain applied.
    function automatic logic [W-1:0] rot_x(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        real zr;
        int  r;
        zr = $itor($signed(z)) / 1024.0;
        r  = q10(GAIN * ($itor($signed(x)) * $cos(zr) - $itor($signed(y)) * $sin(zr)));
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rot_y(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        real zr;
        int  r;
        zr = $itor($signed(z)) / 1024.0;
        r  = q10(GAIN * ($itor($signed(x)) * $sin(zr) + $itor($signed(y)) * $cos(zr)));
        return r[W-1:0];
    endfunction

    logic [W-1:0] px_q [PIPE_LAT];
    logic [W-1:0] py_q [PIPE_LAT];

    always @(posedge clk) begin
        px_q[0] <= rot_x(x0, y0, z0);
        py_q[0] <= rot_y(x0, y0, z0);
        for (int i = 1; i < PIPE_LAT; i++) begin
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
        end
    end

    assign pipe_x = px_q[PIPE_LAT-1];
    assign pipe_y = py_q[PIPE_LAT-1];

    function automatic int ref_angle(input int a);
`ifdef CORDIC_RANGE_CHECK_EN
        if (a > 3217) return 3217;
        if (a < -3217) return -3217;
`endif
        return a;
    endfunction

    function automatic int exp_cos(input int a);
        return q10(1024.0 * $cos($itor(ref_angle(a)) / 1024.0));
    endfunction

    function automatic int exp_sin(input int a);
        return q10(1024.0 * $sin($itor(ref_angle(a)) / 1024.0));
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Scoreboard: record accepted angles, compare every popped result.
    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        check_val("extra_pop", 1, 0, 0);
                    end else begin
                        a = exp_q.pop_front();
                        check_val("cos", int'($signed(out_cos)), exp_cos(a), 4);
                        check_val("sin", int'($signed(out_sin)), exp_sin(a), 4);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(int'($signed(in_angle)));
            end
        end
    end

    task automatic send(input int ang);
        int guard = 0;
        in_valid = 1'b1;
        in_angle = ang[W-1:0];
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check_val("send_timeout", guard, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("drain_empty", exp_q.size(), 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int acc;
        int seen;
        int bnd[8];
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 1, 0);
        check_val("rst_out_valid", out_valid, 0, 0);
        check_val("rst_out_cos", out_cos, 0, 0);
        check_val("rst_out_sin", out_sin, 0, 0);
        check_val("rst_x0", x0, 0, 0);
        check_val("rst_y0", y0, 0, 0);
        check_val("rst_z0", z0, 0, 0);
`ifdef CORDIC_RANGE_CHECK_EN
        check_val("rst_err", err, 0, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero angle: launch values and latency.
        in_valid = 1'b1;
        in_angle = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("x0_k", x0, 622, 0);
        check_val("y0_zero", y0, 0, 0);
        check_val("z0_zero", z0, 0, 0);
        k = 0;
        while (!out_valid && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("latency", k, 13, 0);
        drain();

        // Second/third quadrant reduction.
        send('h0A00);
        check_val("z0_pos2p5", z0, 'hFD6F, 0);
        send(-2560);
        check_val("z0_neg2p5", z0, 'h0291, 0);
        drain();

        // Boundaries around +/- pi/2 and +/- pi.
        bnd = '{1608, 1609, -1608, -1609, 3217, -3217, 1, -1};
        foreach (bnd[i]) send(bnd[i]);
        drain();

        // Backpressure: only FIFO_DEPTH of a 6-angle burst get in.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_angle = 16'(200 * i - 500);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("burst_accepted", acc, 4, 0);
        check_val("burst_in_ready", in_ready, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        check_val("full_in_ready", in_ready, 0, 0);
        check_val("full_out_valid", out_valid, 1, 0);
        pops = 0;
        drain();
        check_val("burst_pops", pops, 4, 0);

        // Reset with samples in flight.
        out_ready = 1'b0;
        send(300);
        send(-900);
        send(2000);
        repeat (11) @(posedge clk);
        #1;
        check_val("pre_rst_valid", out_valid, 1, 0);
        rst = 1'b1;
        #1;
        check_val("rst_now_out_valid", out_valid, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("post_rst_in_ready", in_ready, 1, 0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val("post_rst_quiet", seen, 0, 0);

        // Randomized angles with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            send(int'($urandom_range(0, 6434)) - 3217);
        end
        drain();

`ifdef CORDIC_RANGE_CHECK_EN
        send(3328);
        check_val("err_set", err, 1, 0);
        send(0);
        send(-3400);
        send(1000);
        check_val("err_sticky", err, 1, 0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
